dram_fifo: RTL and testbench
============================

DRAM_FIFO -- requirements
Module: dram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 32, word capacity; power of two, 16..256.
REQ-003 SHALL have parameter AFULL_LVL, default 28, COUNT threshold at or above which AFULL asserts (1..DEPTH-1).
REQ-004 SHALL have port CLK, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port RSTN, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port CLR, input, 1, synchronous flush.
REQ-007 SHALL have port DI, input, WIDTH, write data.
REQ-008 SHALL have port WR, input, 1, push request.
REQ-009 SHALL have port RD, input, 1, pop request (acknowledge of DO).
REQ-010 SHALL have port DO, output, WIDTH, head-of-queue data (first-word-fall-through).
REQ-011 SHALL have port VALID, output, 1, DO holds a valid word.
REQ-012 SHALL have port FULL, output, 1, COUNT equals DEPTH.
REQ-013 SHALL have port AFULL, output, 1, COUNT >= AFULL_LVL.
REQ-014 SHALL have port COUNT, output, log2(DEPTH)+1, words stored.
REQ-015 SHALL have port OVF, output, 1, sticky overflow flag.
REQ-016 SHALL have port UDF, output, 1, sticky underflow flag.

Function
REQ-017 Storage SHALL be distributed RAM: synchronous write, asynchronous read.
REQ-018 Push SHALL be accepted on an edge when WR=1 and FULL=0: RAM[wptr]<=DI, wptr+1 mod DEPTH.
REQ-019 Pop SHALL be accepted on an edge when RD=1 and VALID=1: rptr+1 mod DEPTH.
REQ-020 DO SHALL equal RAM[rptr] combinationally; DO is don't-care when VALID=0.
REQ-021 Write-to-VALID latency SHALL be one edge: a word pushed into an empty FIFO is on DO with VALID=1 immediately after that edge.
REQ-022 COUNT SHALL be +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 Simultaneous push and pop SHALL both be accepted whenever 0<COUNT<DEPTH.
REQ-024 When FULL, WR SHALL be dropped even if RD=1 that edge; pop proceeds.
REQ-025 When empty, RD SHALL be ignored; a same-edge WR proceeds.
REQ-026 WR while FULL SHALL set OVF; RD while VALID=0 SHALL set UDF; both stay set until CLR or reset.
REQ-027 Pointers SHALL be log2(DEPTH) bits and wrap naturally; FULL/empty SHALL be derived from COUNT.
REQ-028 VALID SHALL equal (COUNT!=0); FULL, AFULL SHALL be decoded from registered COUNT, glitch-free.
REQ-029 CLR=1 SHALL on that edge zero wptr, rptr, COUNT, OVF, UDF; WR and RD that edge SHALL be ignored; RAM contents are not cleared.

Reset
REQ-030 RSTN=0 SHALL asynchronously force wptr=0, rptr=0, COUNT=0, VALID=0, FULL=0, AFULL=0, OVF=0, UDF=0.
REQ-031 RSTN assertion mid-operation SHALL discard all stored words; RAM contents are left undefined and never observed.
REQ-032 Deassertion of RSTN SHALL be synchronised externally; the first edge after release SHALL accept WR.

Structure
REQ-033 Shared package SHALL hold clog2 function and pointer/count width derivation; no block-local constants are duplicated.
REQ-034 Storage SHALL be one sub-module dram_sdp (params WIDTH, DEPTH; ports WADDR, RADDR, DI, DO, WE, WCLK), built from 32- or 64-deep 6-bit distributed RAM primitives.
REQ-035 Control (pointers, COUNT, flags) SHALL reside in dram_fifo; no state inside dram_sdp other than RAM.

Verification
REQ-036 Reset, push 0x123 once -> next cycle VALID=1, DO=0x123, COUNT=1; RD one edge -> VALID=0, COUNT=0.
REQ-037 Push 32 words 0x000..0x01F with RD=0 -> AFULL rises when COUNT=28, FULL=1 at 32; 33rd WR -> dropped, OVF=1, COUNT=32.
REQ-038 From COUNT=32, WR=RD=1 one edge -> pop accepted, push dropped, COUNT=31, OVF=1.
REQ-039 Continuous WR=RD=1 for 100 edges from COUNT=5 -> COUNT stays 5, DO sequence in order across pointer wrap.
REQ-040 RD with COUNT=0 -> UDF=1, COUNT=0; then CLR -> UDF=0, OVF=0, COUNT=0, VALID=0.
REQ-041 RSTN pulsed low between clock edges with COUNT=10 -> COUNT=0, VALID=0 immediately, before the next edge.

Source files
------------

// File: rtl/dram_fifo_pkg.sv
// Shared width helpers for the distributed-RAM FIFO and its storage block.
package dram_fifo_pkg;

    // Native depth/width of the distributed RAM primitive slices.
    localparam int unsigned PRIM_WIDTH = 6;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Read/write pointer width: pointers wrap naturally at DEPTH.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2(depth);
    endfunction

    // Occupancy width: one extra bit so that COUNT can reach DEPTH.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    // Depth of the primitive used to build the RAM (32- or 64-deep).
    function automatic int unsigned prim_depth(input int unsigned depth);
        return (depth <= 32) ? 32 : 64;
    endfunction

endpackage

// File: rtl/dram_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Built as a grid of banks x 6-bit slices of 32/64-deep primitives.
module dram_sdp
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 32
) (
    input  logic                    WCLK,
    input  logic                    WE,
    input  logic [ptr_w(DEPTH)-1:0] WADDR,
    input  logic [ptr_w(DEPTH)-1:0] RADDR,
    input  logic [WIDTH-1:0]        DI,
    output logic [WIDTH-1:0]        DO
);

    localparam int unsigned AW     = ptr_w(DEPTH);
    localparam int unsigned PD     = prim_depth(DEPTH);
    localparam int unsigned PAW    = clog2(PD);
    localparam int unsigned NBANK  = (DEPTH > PD) ? DEPTH / PD : 1;
    localparam int unsigned BW     = (NBANK > 1) ? clog2(NBANK) : 1;
    localparam int unsigned NSLICE = (WIDTH + PRIM_WIDTH - 1) / PRIM_WIDTH;

    logic [PAW-1:0] wa_p;
    logic [PAW-1:0] ra_p;
    logic [BW-1:0]  wbank;
    logic [BW-1:0]  rbank;
    logic [NBANK-1:0][WIDTH-1:0] rd_bank;

    // Low address bits index inside a primitive; upper bits pick the bank.
    assign wa_p = PAW'(WADDR);
    assign ra_p = PAW'(RADDR);

    if (NBANK > 1) begin : g_bank_sel
        assign wbank = WADDR[AW-1:PAW];
        assign rbank = RADDR[AW-1:PAW];
    end else begin : g_single_bank
        assign wbank = '0;
        assign rbank = '0;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar s = 0; s < NSLICE; s++) begin : g_slice
            // Last slice may be narrower than a full primitive.
            localparam int unsigned LO = s * PRIM_WIDTH;
            localparam int unsigned SW = ((WIDTH - LO) < PRIM_WIDTH) ? (WIDTH - LO) : PRIM_WIDTH;

            logic [SW-1:0] ram [PD];

            // Synchronous write into the selected bank.
            always_ff @(posedge WCLK) begin
                if (WE && (wbank == BW'(b))) begin
                    ram[wa_p] <= DI[LO +: SW];
                end
            end

            assign rd_bank[b][LO +: SW] = ram[ra_p];
        end
    end

    assign DO = rd_bank[rbank];

endmodule

// File: rtl/dram_fifo.sv
// First-word-fall-through FIFO over distributed RAM with occupancy count,
// almost-full threshold and sticky overflow/underflow flags.
module dram_fifo
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AFULL_LVL = 28
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    CLR,
    input  logic [WIDTH-1:0]        DI,
    input  logic                    WR,
    input  logic                    RD,
    output logic [WIDTH-1:0]        DO,
    output logic                    VALID,
    output logic                    FULL,
    output logic                    AFULL,
    output logic [cnt_w(DEPTH)-1:0] COUNT,
    output logic                    OVF,
    output logic                    UDF
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic full;
    logic valid;
    logic push;
    logic pop;

    // Status is decoded from the registered count only.
    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = WR && !full && !CLR;
    assign pop   = RD && valid && !CLR;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (CLR) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (WR && full) begin
                ovf_d = 1'b1;
            end
            if (RD && !valid) begin
                udf_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    dram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .WCLK  (CLK),
        .WE    (push),
        .WADDR (wptr_q),
        .RADDR (rptr_q),
        .DI    (DI),
        .DO    (DO)
    );

    assign VALID = valid;
    assign FULL  = full;
    assign AFULL = (count_q >= CW'(AFULL_LVL));
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

endmodule

// File: tb/tb_dram_fifo.sv
// Bench for dram_fifo: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model.
module tb_dram_fifo;

    localparam int unsigned WIDTH     = 12;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned AFULL_LVL = 28;
    localparam int unsigned CW        = 6;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             CLR;
    logic [WIDTH-1:0] DI;
    logic             WR;
    logic             RD;
    logic [WIDTH-1:0] DO;
    logic             VALID;
    logic             FULL;
    logic             AFULL;
    logic [CW-1:0]    COUNT;
    logic             OVF;
    logic             UDF;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents in arrival order plus sticky flags.
    int unsigned mq[$];
    bit          m_ovf;
    bit          m_udf;

    always #5 CLK = ~CLK;

    dram_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .CLR   (CLR),
        .DI    (DI),
        .WR    (WR),
        .RD    (RD),
        .DO    (DO),
        .VALID (VALID),
        .FULL  (FULL),
        .AFULL (AFULL),
        .COUNT (COUNT),
        .OVF   (OVF),
        .UDF   (UDF)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned n;
        n = mq.size();
        check_eq({tag, ".count"}, 64'(COUNT), 64'(n));
        check_eq({tag, ".valid"}, 64'(VALID), 64'(n != 0));
        check_eq({tag, ".full"},  64'(FULL),  64'(n == DEPTH));
        check_eq({tag, ".afull"}, 64'(AFULL), 64'(n >= AFULL_LVL));
        check_eq({tag, ".ovf"},   64'(OVF),   64'(m_ovf));
        check_eq({tag, ".udf"},   64'(UDF),   64'(m_udf));
        if (n != 0) begin
            check_eq({tag, ".do"}, 64'(DO), 64'(mq[0]));
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check 1ns later.
    task automatic step(input string tag, input bit wr, input bit rd, input bit clr,
                        input logic [WIDTH-1:0] di);
        int unsigned n;
        @(negedge CLK);
        WR  = wr;
        RD  = rd;
        CLR = clr;
        DI  = di;
        @(posedge CLK);
        n = mq.size();
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr && n == DEPTH) m_ovf = 1'b1;
            if (rd && n == 0) m_udf = 1'b1;
            if (rd && n != 0) void'(mq.pop_front());
            if (wr && n != DEPTH) mq.push_back(int'(di));
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    initial begin
        int unsigned seq;
        int unsigned pw;
        int unsigned pr;
        RSTN = 1'b0;
        CLR  = 1'b0;
        WR   = 1'b0;
        RD   = 1'b0;
        DI   = '0;
        model_reset();
        #2;
        check_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;

        // Single word: fall-through on the very next edge, then pop it.
        step("one_push", 1'b1, 1'b0, 1'b0, 12'h123);
        check_eq("one_push.do_const", 64'(DO), 64'h123);
        step("one_pop", 1'b0, 1'b1, 1'b0, 12'h000);
        check_eq("one_pop.valid_const", 64'(VALID), 64'd0);

        // Fill to 32, threshold crossing at 28, then overflow on 33rd write.
        for (int i = 0; i < 32; i++) begin
            step("fill", 1'b1, 1'b0, 1'b0, WIDTH'(i));
        end
        check_eq("fill.full_const", 64'(FULL), 64'd1);
        step("ovf_wr", 1'b1, 1'b0, 1'b0, 12'hABC);
        check_eq("ovf_wr.count_const", 64'(COUNT), 64'd32);

        // Full with WR=RD: pop proceeds, push dropped.
        step("full_wrrd", 1'b1, 1'b1, 1'b0, 12'hDEF);
        check_eq("full_wrrd.count_const", 64'(COUNT), 64'd31);

        // Steady-state streaming across pointer wrap at COUNT=5.
        step("clr1", 1'b0, 1'b0, 1'b1, 12'h000);
        seq = 12'h400;
        for (int i = 0; i < 5; i++) begin
            step("pre5", 1'b1, 1'b0, 1'b0, WIDTH'(seq));
            seq++;
        end
        for (int i = 0; i < 100; i++) begin
            step("stream", 1'b1, 1'b1, 1'b0, WIDTH'(seq));
            seq++;
        end
        check_eq("stream.count_const", 64'(COUNT), 64'd5);

        // Underflow, then CLR clears everything; CLR-edge WR is ignored.
        while (mq.size() != 0) step("drain", 1'b0, 1'b1, 1'b0, 12'h000);
        step("udf_rd", 1'b0, 1'b1, 1'b0, 12'h000);
        check_eq("udf_rd.udf_const", 64'(UDF), 64'd1);
        step("clr2", 1'b1, 1'b1, 1'b1, 12'h555);

        // Asynchronous reset between edges with ten words stored.
        for (int i = 0; i < 10; i++) begin
            step("pre10", 1'b1, 1'b0, 1'b0, WIDTH'(12'h700 + i));
        end
        @(posedge CLK);
        #2;
        RSTN = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst.count", 64'(COUNT), 64'd0);
        check_eq("async_rst.valid", 64'(VALID), 64'd0);
        #1;
        RSTN = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b0, 12'h321);

        // Randomized traffic with phases biased toward filling or draining.
        for (int ph = 0; ph < 15; ph++) begin
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int i = 0; i < 200; i++) begin
                step("rand",
                     $urandom_range(99) < pw,
                     $urandom_range(99) < pr,
                     $urandom_range(299) == 0,
                     WIDTH'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
